timing_ctrl: RTL and testbench
==============================

TIMING_CTRL -- requirements
Module: timing_ctrl

Interface
REQ-001 SHALL have parameter INT_OP, default 8'h00, the opcode forced into the instruction register for interrupt/reset service.
REQ-002 SHALL have parameter CYC_W, default 3, the cycle counter width.
REQ-003 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port clr  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port dbus  in  8  data bus, the opcode source at fetch.
REQ-006 SHALL have ports icyc, rcyc, scyc, sinst  in  1 each  sequencing requests from the instruction decoder.
REQ-007 SHALL have port nmi  in  1  non-maskable interrupt request, rising-edge sensitive.
REQ-008 SHALL have port irq  in  1  maskable interrupt request, level sensitive, active-high.
REQ-009 SHALL have port irqdis  in  1  status-register interrupt-disable flag.
REQ-010 SHALL have port inst  out  8  instruction register, feeds the decoder's inst input.
REQ-011 SHALL have port cycle  out  CYC_W  cycle counter, feeds the decoder's cycle input.
REQ-012 SHALL have ports svc_clr, svc_nmi, svc_irq  out  1 each  one-hot service select, feeds the decoder's clr/nmi/irq inputs.
REQ-013 SHALL have port sync  out  1  high when cycle==0.
REQ-014 SHALL have port illegal  out  1  one-cycle pulse flagging a sequencing fault.

Function
REQ-015 Cycle update priority SHALL be rcyc > scyc > icyc.
REQ-016 rcyc SHALL set cycle to 0 and load inst at the same edge.
REQ-017 scyc SHALL hold cycle and inst.
REQ-018 icyc SHALL increment cycle by 1.
REQ-019 icyc at cycle == 2^CYC_W-1 SHALL NOT wrap silently: it SHALL be treated as rcyc and SHALL pulse illegal.
REQ-020 A cycle with none of icyc/rcyc/scyc asserted SHALL be treated as rcyc and SHALL pulse illegal, so an unknown opcode cannot stall the core.
REQ-021 NMI edge: nmi SHALL be registered each cycle; nmi high with previous sample low SHALL set nmi_pend.
REQ-022 Reset pending: rst_pend SHALL be set by clr.
REQ-023 IRQ pending: irq_act SHALL equal irq AND NOT irqdis, evaluated combinationally at the boundary.
REQ-024 At every rcyc-type edge (including the forced cases of REQ-019/020), the svc_* register SHALL load a one-hot selection by priority rst_pend > nmi_pend > irq_act, or all-zero if none is pending.
REQ-025 At the same edge, inst SHALL load INT_OP if any source is selected, else dbus.
REQ-026 svc_* SHALL be held constant until the next rcyc-type edge.
REQ-027 sinst SHALL clear the pending flag of the currently selected source: rst_pend if svc_clr, nmi_pend if svc_nmi; irq has no latch.
REQ-028 A new NMI edge on the same cycle as its sinst clear SHALL win, leaving nmi_pend = 1.
REQ-029 An NMI arriving mid-instruction SHALL be serviced at the next boundary; irq deasserted before the boundary SHALL be ignored.
REQ-030 Latency: from nmi rising edge to svc_nmi SHALL be at most the remaining cycles of the current instruction + 1.

Reset
REQ-031 clr SHALL asynchronously force: cycle=0, inst=INT_OP, svc_clr=1, svc_nmi=0, svc_irq=0, rst_pend=1, nmi_pend=0, nmi sample=0, illegal=0.
REQ-032 Assertion of clr mid-instruction SHALL abandon the instruction; after release, the first cycle SHALL be cycle 0 of reset service.

Structure
REQ-033 Shared package timing_pkg SHALL hold INT_OP, CYC_W, and a service-select enum (SVC_NONE, SVC_CLR, SVC_NMI, SVC_IRQ) with its one-hot mapping.
REQ-034 NMI edge detection SHALL be a sub-module edge_det (register + rising-edge pulse); all other logic SHALL be flat.

Verification
REQ-035 Reset scenario: release clr, decoder returns icyc x7 then rcyc with dbus=0xA9 -> cycles 0..7, svc_clr=1 throughout, then inst=0xA9, cycle=0, svc all 0.
REQ-036 Immediate load scenario: dbus=0xA9, icyc,icyc,icyc,rcyc with dbus=0x18 -> cycle 0,1,2,3,0; inst=0x18.
REQ-037 NMI vs IRQ priority: nmi pulse at cycle 1 and irq=1, irqdis=0 -> at boundary inst=0x00, svc_nmi=1; after sinst, next boundary with irq still high -> svc_irq=1.
REQ-038 Masked IRQ: irq=1, irqdis=1 at boundary -> inst=dbus, svc all 0; irqdis falls -> serviced at next boundary.
REQ-039 Faults: icyc at cycle 7, or no request -> cycle=0, inst loaded, illegal pulses for exactly 1 cycle.
REQ-040 Reset mid-instruction: clr asserted asynchronously at cycle 3 -> outputs immediately reach REQ-031 values without waiting for a clk edge.

Source files
------------

// File: rtl/timing_ctrl_pkg.sv
// Shared definitions for the timing controller: default interrupt opcode,
// cycle counter width and the service-select encoding.
package timing_pkg;

  localparam logic [7:0] INT_OP = 8'h00;
  localparam int         CYC_W  = 3;

  typedef enum logic [1:0] {
    SVC_NONE,
    SVC_CLR,
    SVC_NMI,
    SVC_IRQ
  } svc_e;

  // One-hot image of a service select, ordered {clr, nmi, irq}.
  function automatic logic [2:0] svc_onehot(input svc_e sel);
    case (sel)
      SVC_CLR: return 3'b100;
      SVC_NMI: return 3'b010;
      SVC_IRQ: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/timing_ctrl_if.sv
// Decoder <-> timing controller signal bundle. The master side is the
// instruction decoder / bus, the slave side is the timing controller.
interface timing_ctrl_if #(
  parameter int CYC_W = timing_pkg::CYC_W
);
  logic [7:0]       dbus;
  logic             icyc;
  logic             rcyc;
  logic             scyc;
  logic             sinst;
  logic             nmi;
  logic             irq;
  logic             irqdis;
  logic [7:0]       inst;
  logic [CYC_W-1:0] cycle;
  logic             svc_clr;
  logic             svc_nmi;
  logic             svc_irq;
  logic             sync;
  logic             illegal;

  modport master (
    output dbus, icyc, rcyc, scyc, sinst, nmi, irq, irqdis,
    input  inst, cycle, svc_clr, svc_nmi, svc_irq, sync, illegal
  );

  modport slave (
    input  dbus, icyc, rcyc, scyc, sinst, nmi, irq, irqdis,
    output inst, cycle, svc_clr, svc_nmi, svc_irq, sync, illegal
  );
endinterface

// File: rtl/timing_ctrl_edge_det.sv
// Registers a level input and flags its rising edge (input high while the
// previous sample was low).
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic q;

  // Previous-cycle sample of d.
  // NOTE: state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  assign rise = d & ~q;
endmodule

// File: rtl/timing_ctrl.sv
// Instruction timing controller: cycle counter, instruction register,
// interrupt/reset pending latches and the one-hot service select.
module timing_ctrl #(
  parameter logic [7:0] INT_OP = timing_pkg::INT_OP,
  parameter int         CYC_W  = timing_pkg::CYC_W
) (
  input logic          clk,
  input logic          clr,
  timing_ctrl_if.slave bus
);
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  logic [CYC_W-1:0]  cycle_q;
  logic [7:0]        inst_q;
  logic [2:0]        svc_q;     // {clr, nmi, irq}
  logic              illegal_q;
  logic              rst_pend;
  logic              nmi_pend;
  logic              nmi_rise;
  logic              fault;
  logic              boundary;
  logic              irq_act;
  timing_pkg::svc_e  sel;

  edge_det u_nmi_edge (
    .clk  (clk),
    .rst  (clr),
    .d    (bus.nmi),
    .rise (nmi_rise)
  );

  // Boundary decode and service arbitration. A missing request or an
  // increment past the last cycle is forced into a boundary so the core
  // can never stall or wrap silently.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fault    = 1'b0;
    boundary = 1'b0;
    irq_act  = bus.irq & ~bus.irqdis;
    sel      = timing_pkg::SVC_NONE;
    if (!bus.rcyc && !bus.scyc)
      fault = !bus.icyc || (cycle_q == CYC_MAX);
    boundary = bus.rcyc || fault;
    if (rst_pend)      sel = timing_pkg::SVC_CLR;
    else if (nmi_pend) sel = timing_pkg::SVC_NMI;
    else if (irq_act)  sel = timing_pkg::SVC_IRQ;
  end

  // Cycle counter, instruction register, service select and fault pulse.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cycle_q   <= '0;
      inst_q    <= INT_OP;
      svc_q     <= timing_pkg::svc_onehot(timing_pkg::SVC_CLR);
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= fault;
      if (boundary) begin
        cycle_q <= '0;
        svc_q   <= timing_pkg::svc_onehot(sel);
        inst_q  <= (sel != timing_pkg::SVC_NONE) ? INT_OP : bus.dbus;
      end else if (!bus.scyc) begin
        cycle_q <= cycle_q + CYC_W'(1);
      end
    end
  end

  // Pending latches. sinst retires the source being serviced; a fresh NMI
  // edge in that same cycle takes precedence so it is not lost.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rst_pend <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      if (bus.sinst && svc_q[2]) rst_pend <= 1'b0;
      if (nmi_rise)                     nmi_pend <= 1'b1;
      else if (bus.sinst && svc_q[1])   nmi_pend <= 1'b0;
    end
  end

  assign bus.cycle   = cycle_q;
  assign bus.inst    = inst_q;
  assign bus.svc_clr = svc_q[2];
  assign bus.svc_nmi = svc_q[1];
  assign bus.svc_irq = svc_q[0];
  assign bus.sync    = (cycle_q == '0);
  assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_timing_ctrl.sv
// Directed, table-driven bench for timing_ctrl plus hand-written sequences
// for asynchronous reset behaviour.
module tb_timing_ctrl;
  // Request bit positions: {icyc, rcyc, scyc, sinst, nmi, irq, irqdis}
  localparam logic [6:0] I  = 7'b1000000;
  localparam logic [6:0] R  = 7'b0100000;
  localparam logic [6:0] S  = 7'b0010000;
  localparam logic [6:0] SI = 7'b0001000;
  localparam logic [6:0] N  = 7'b0000100;
  localparam logic [6:0] Q  = 7'b0000010;
  localparam logic [6:0] D  = 7'b0000001;
  localparam logic [6:0] Z  = 7'b0000000;

  typedef struct {
    logic [6:0] req;
    logic [7:0] dbus;
    logic [2:0] e_cyc;
    logic [7:0] e_inst;
    logic [2:0] e_svc;   // {clr, nmi, irq}
    logic       e_ill;
  } vec_t;

  logic clk;
  logic clr;
  int   checks;
  int   failures;
  vec_t vq[$];

  timing_ctrl_if #(.CYC_W(3)) bus ();

  timing_ctrl #(.INT_OP(8'h00), .CYC_W(3)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] cyc, input logic [7:0] inst,
                           input logic [2:0] svc, input logic ill);
    check({tag, " cycle"},   32'(bus.cycle), 32'(cyc));
    check({tag, " inst"},    32'(bus.inst), 32'(inst));
    check({tag, " svc"},     32'({bus.svc_clr, bus.svc_nmi, bus.svc_irq}), 32'(svc));
    check({tag, " illegal"}, 32'(bus.illegal), 32'(ill));
    check({tag, " sync"},    32'(bus.sync), 32'(cyc == 3'd0));
  endtask

  task automatic drive(input logic [6:0] r, input logic [7:0] d);
    {bus.icyc, bus.rcyc, bus.scyc, bus.sinst, bus.nmi, bus.irq, bus.irqdis} = r;
    bus.dbus = d;
  endtask

  task automatic add(input logic [6:0] r, input logic [7:0] d, input logic [2:0] c,
                     input logic [7:0] i, input logic [2:0] s, input logic l);
    vec_t v;
    v.req = r; v.dbus = d; v.e_cyc = c; v.e_inst = i; v.e_svc = s; v.e_ill = l;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr      = 1'b1;
    drive(Z, 8'h00);

    // Reset service: icyc x7 (sinst retires reset), then rcyc loads A9.
    for (int k = 1; k <= 7; k++)
      add((k == 6) ? (I | SI) : I, 8'h00, 3'(k), 8'h00, 3'b100, 1'b0);
    add(R, 8'hA9, 3'd0, 8'hA9, 3'b000, 1'b0);
    // Immediate load, then scyc hold and rcyc-over-scyc priority.
    add(I,     8'hA9, 3'd1, 8'hA9, 3'b000, 1'b0);
    add(I,     8'hA9, 3'd2, 8'hA9, 3'b000, 1'b0);
    add(I,     8'hA9, 3'd3, 8'hA9, 3'b000, 1'b0);
    add(R,     8'h18, 3'd0, 8'h18, 3'b000, 1'b0);
    add(I,     8'h18, 3'd1, 8'h18, 3'b000, 1'b0);
    add(S | I, 8'h18, 3'd1, 8'h18, 3'b000, 1'b0);
    add(R | S, 8'h55, 3'd0, 8'h55, 3'b000, 1'b0);
    // NMI beats IRQ; after sinst the still-high IRQ is taken; then IRQ drops.
    add(I,          8'h77, 3'd1, 8'h55, 3'b000, 1'b0);
    add(I | N | Q,  8'h77, 3'd2, 8'h55, 3'b000, 1'b0);
    add(I | Q,      8'h77, 3'd3, 8'h55, 3'b000, 1'b0);
    add(R | Q,      8'h77, 3'd0, 8'h00, 3'b010, 1'b0);
    add(I | SI | Q, 8'h77, 3'd1, 8'h00, 3'b010, 1'b0);
    add(R | Q,      8'h77, 3'd0, 8'h00, 3'b001, 1'b0);
    add(R,          8'h12, 3'd0, 8'h12, 3'b000, 1'b0);
    // Masked IRQ, then unmasked at the following boundary.
    add(R | Q | D,  8'h34, 3'd0, 8'h34, 3'b000, 1'b0);
    add(I | Q,      8'h34, 3'd1, 8'h34, 3'b000, 1'b0);
    add(R | Q,      8'h34, 3'd0, 8'h00, 3'b001, 1'b0);
    add(R,          8'h56, 3'd0, 8'h56, 3'b000, 1'b0);
    // Faults: icyc past the last cycle, and no request at all.
    for (int k = 1; k <= 7; k++)
      add(I, 8'h56, 3'(k), 8'h56, 3'b000, 1'b0);
    add(I, 8'h9A, 3'd0, 8'h9A, 3'b000, 1'b1);
    add(I, 8'h9A, 3'd1, 8'h9A, 3'b000, 1'b0);
    add(Z, 8'h3C, 3'd0, 8'h3C, 3'b000, 1'b1);
    add(R, 8'h3C, 3'd0, 8'h3C, 3'b000, 1'b0);
    // New NMI edge in the same cycle as its sinst clear keeps it pending.
    add(I | N,      8'h3C, 3'd1, 8'h3C, 3'b000, 1'b0);
    add(I,          8'h3C, 3'd2, 8'h3C, 3'b000, 1'b0);
    add(R,          8'h11, 3'd0, 8'h00, 3'b010, 1'b0);
    add(I | N | SI, 8'h11, 3'd1, 8'h00, 3'b010, 1'b0);
    add(I,          8'h11, 3'd2, 8'h00, 3'b010, 1'b0);
    add(R,          8'h11, 3'd0, 8'h00, 3'b010, 1'b0);
    add(I | SI,     8'h11, 3'd1, 8'h00, 3'b010, 1'b0);
    add(R,          8'h22, 3'd0, 8'h22, 3'b000, 1'b0);

    // Reset state, with clr held across a clock edge.
    #12;
    check_out("reset", 3'd0, 8'h00, 3'b100, 1'b0);
    clr = 1'b0;

    foreach (vq[n]) begin
      drive(vq[n].req, vq[n].dbus);
      tick();
      check_out($sformatf("vec%0d", n), vq[n].e_cyc, vq[n].e_inst, vq[n].e_svc, vq[n].e_ill);
    end

    // Asynchronous clr drops a pending fault pulse immediately.
    drive(Z, 8'h44);
    tick();
    check_out("pre_clr_fault", 3'd0, 8'h44, 3'b000, 1'b1);
    #2 clr = 1'b1;
    #1 check_out("async_clr_fault", 3'd0, 8'h00, 3'b100, 1'b0);
    clr = 1'b0;
    drive(I | SI, 8'h44);
    tick();
    check_out("rst_svc_after_fault", 3'd1, 8'h00, 3'b100, 1'b0);
    drive(R, 8'h66);
    tick();
    check_out("load_66", 3'd0, 8'h66, 3'b000, 1'b0);

    // clr at cycle 3 abandons the instruction without waiting for clk.
    drive(I, 8'h66);
    tick(); tick(); tick();
    check_out("mid_instr_c3", 3'd3, 8'h66, 3'b000, 1'b0);
    #2 clr = 1'b1;
    #1 check_out("async_clr_mid", 3'd0, 8'h00, 3'b100, 1'b0);
    tick();
    check_out("clr_held_edge", 3'd0, 8'h00, 3'b100, 1'b0);
    clr = 1'b0;
    #1 check_out("clr_release", 3'd0, 8'h00, 3'b100, 1'b0);
    drive(I, 8'h66);
    tick();
    check_out("rst_svc_c1", 3'd1, 8'h00, 3'b100, 1'b0);
    drive(I | SI, 8'h66);
    tick();
    check_out("rst_svc_c2", 3'd2, 8'h00, 3'b100, 1'b0);
    drive(R, 8'h5A);
    tick();
    check_out("load_5a", 3'd0, 8'h5A, 3'b000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
